// File: rtl/bip2_fetch.sv
// rtl/bip2_fetch.sv - BIP-2 instruction fetch stage (PC, IR, branch/stall, HLT freeze)
// Optional HLT detection and HALTED state are built when BIP2_FETCH_HALT_DETECT_EN is defined.
module bip2_fetch #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 16,
  parameter int OPC_W  = 5
) (
  input  logic                    CLK_i,
  input  logic                    RST_i,
  output logic [ADDR_W-1:0]       ADDR_im_o,
  input  logic [DATA_W-1:0]       DATA_im_i,
  input  logic                    STALL_i,
  input  logic                    BRANCH_EN_i,
  input  logic [ADDR_W-1:0]       BRANCH_ADDR_i,
  output logic [DATA_W-1:0]       INSTR_o,
  output logic [OPC_W-1:0]        OPCODE_o,
  output logic [DATA_W-OPC_W-1:0] OPERAND_o,
  output logic [ADDR_W-1:0]       PC_o,
  output logic                    INSTR_VALID_o,
  output logic                    HALT_o
);

  logic [ADDR_W-1:0] pc_q, pc_n;
  logic [DATA_W-1:0] ir_q, ir_n;
  logic [ADDR_W-1:0] fpc_q, fpc_n;
  logic              valid_q, valid_n;

`ifdef BIP2_FETCH_HALT_DETECT_EN
  typedef enum logic {S_RUN, S_HALTED} state_t;
  state_t state_q, state_n;
  logic   hlt_fetch;

  // HLT is recognised from the ROM word being fetched, not from the IR.
  assign hlt_fetch = (DATA_im_i[DATA_W-1 -: OPC_W] == '0);

  always_ff @(posedge CLK_i) begin
    if (RST_i) begin
      state_q <= S_RUN;
    end else begin
      state_q <= state_n;
    end
  end

  always_comb begin
    pc_n    = pc_q;
    ir_n    = ir_q;
    fpc_n   = fpc_q;
    valid_n = valid_q;
    state_n = state_q;
    case (state_q)
      S_RUN: begin
        if (BRANCH_EN_i) begin
          pc_n    = BRANCH_ADDR_i;
          valid_n = 1'b0;
        end else if (!STALL_i) begin
          ir_n    = DATA_im_i;
          fpc_n   = pc_q;
          valid_n = 1'b1;
          if (hlt_fetch) begin
            state_n = S_HALTED;
          end else begin
            pc_n = pc_q + ADDR_W'(1);
          end
        end
      end
      S_HALTED: begin
        valid_n = 1'b0;
      end
      default: begin
        state_n = S_RUN;
      end
    endcase
  end

  assign HALT_o = (state_q == S_HALTED);
`else
  always_comb begin
    pc_n    = pc_q;
    ir_n    = ir_q;
    fpc_n   = fpc_q;
    valid_n = valid_q;
    if (BRANCH_EN_i) begin
      pc_n    = BRANCH_ADDR_i;
      valid_n = 1'b0;
    end else if (!STALL_i) begin
      ir_n    = DATA_im_i;
      fpc_n   = pc_q;
      valid_n = 1'b1;
      pc_n    = pc_q + ADDR_W'(1);
    end
  end

  assign HALT_o = 1'b0;
`endif

  always_ff @(posedge CLK_i) begin
    if (RST_i) begin
      pc_q    <= '0;
      ir_q    <= '0;
      fpc_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_n;
      ir_q    <= ir_n;
      fpc_q   <= fpc_n;
      valid_q <= valid_n;
    end
  end

  assign ADDR_im_o     = pc_q;
  assign INSTR_o       = ir_q;
  assign OPCODE_o      = ir_q[DATA_W-1 -: OPC_W];
  assign OPERAND_o     = ir_q[DATA_W-OPC_W-1:0];
  assign PC_o          = fpc_q;
  assign INSTR_VALID_o = valid_q;

endmodule

// File: tb/tb_bip2_fetch.sv
// tb/tb_bip2_fetch.sv - directed table-driven bench for bip2_fetch
module tb_bip2_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [10:0] addr;
  logic [15:0] rom_data;
  logic        stall = 1'b0;
  logic        br_en = 1'b0;
  logic [10:0] br_addr = '0;
  logic [15:0] instr;
  logic [4:0]  opcode;
  logic [10:0] operand;
  logic [10:0] pc_o;
  logic        valid;
  logic        halt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  bip2_fetch dut (
    .CLK_i        (clk),
    .RST_i        (rst),
    .ADDR_im_o    (addr),
    .DATA_im_i    (rom_data),
    .STALL_i      (stall),
    .BRANCH_EN_i  (br_en),
    .BRANCH_ADDR_i(br_addr),
    .INSTR_o      (instr),
    .OPCODE_o     (opcode),
    .OPERAND_o    (operand),
    .PC_o         (pc_o),
    .INSTR_VALID_o(valid),
    .HALT_o       (halt)
  );

  // Unlisted cells return opcode 11111 so they never look like HLT.
  function automatic logic [15:0] rom(input logic [10:0] a);
    case (a)
      11'h000: rom = 16'h0801;
      11'h001: rom = 16'hA010;
      11'h002: rom = 16'h1003;
      11'h003: rom = 16'h0011;
      11'h7FF: rom = 16'h0802;
      default: rom = {5'h1F, a};
    endcase
  endfunction

  assign rom_data = rom(addr);

  typedef struct {
    logic        rst;
    logic        stall;
    logic        br;
    logic [10:0] baddr;
    logic [15:0] instr;
    logic [10:0] pc_o;
    logic [10:0] addr;
    logic        valid;
    logic        halt;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mk(input logic r, input logic s, input logic b, input logic [10:0] ba,
                              input logic [15:0] i, input logic [10:0] p, input logic [10:0] a,
                              input logic v, input logic h);
    vec_t t;
    t.rst = r; t.stall = s; t.br = b; t.baddr = ba;
    t.instr = i; t.pc_o = p; t.addr = a; t.valid = v; t.halt = h;
    return t;
  endfunction

  task automatic chk(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic s, input logic b, input logic [10:0] ba);
    rst = r; stall = s; br_en = b; br_addr = ba;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input int idx, input logic [15:0] ei, input logic [10:0] ep,
                           input logic [10:0] ea, input logic ev, input logic eh);
    logic [15:0] e = ei;
    chk({tag, ".instr"},   idx, instr,          ei);
    chk({tag, ".opcode"},  idx, {11'd0, opcode}, {11'd0, e[15:11]});
    chk({tag, ".operand"}, idx, {5'd0, operand}, {5'd0, e[10:0]});
    chk({tag, ".pc_o"},    idx, {5'd0, pc_o},    {5'd0, ep});
    chk({tag, ".addr"},    idx, {5'd0, addr},    {5'd0, ea});
    chk({tag, ".valid"},   idx, {15'd0, valid},  {15'd0, ev});
    chk({tag, ".halt"},    idx, {15'd0, halt},   {15'd0, eh});
  endtask

  initial begin
    //            rst  stl  br   baddr    instr     pc_o     addr     v     h
    vecs[0]  = mk(1'b1,1'b0,1'b0,11'h000, 16'h0000, 11'h000, 11'h000, 1'b0, 1'b0);
    vecs[1]  = mk(1'b1,1'b1,1'b1,11'h123, 16'h0000, 11'h000, 11'h000, 1'b0, 1'b0);
    vecs[2]  = mk(1'b0,1'b0,1'b0,11'h000, 16'h0801, 11'h000, 11'h001, 1'b1, 1'b0);
    vecs[3]  = mk(1'b0,1'b0,1'b0,11'h000, 16'hA010, 11'h001, 11'h002, 1'b1, 1'b0);
    vecs[4]  = mk(1'b0,1'b1,1'b0,11'h000, 16'hA010, 11'h001, 11'h002, 1'b1, 1'b0);
    vecs[5]  = mk(1'b0,1'b1,1'b0,11'h000, 16'hA010, 11'h001, 11'h002, 1'b1, 1'b0);
    vecs[6]  = mk(1'b0,1'b1,1'b0,11'h000, 16'hA010, 11'h001, 11'h002, 1'b1, 1'b0);
    vecs[7]  = mk(1'b0,1'b0,1'b0,11'h000, 16'h1003, 11'h002, 11'h003, 1'b1, 1'b0);
    vecs[8]  = mk(1'b0,1'b1,1'b1,11'h7FF, 16'h1003, 11'h002, 11'h7FF, 1'b0, 1'b0);
    vecs[9]  = mk(1'b0,1'b0,1'b0,11'h000, 16'h0802, 11'h7FF, 11'h000, 1'b1, 1'b0);
    vecs[10] = mk(1'b0,1'b0,1'b1,11'h000, 16'h0802, 11'h7FF, 11'h000, 1'b0, 1'b0);
    vecs[11] = mk(1'b0,1'b0,1'b0,11'h000, 16'h0801, 11'h000, 11'h001, 1'b1, 1'b0);
    vecs[12] = mk(1'b0,1'b0,1'b0,11'h000, 16'hA010, 11'h001, 11'h002, 1'b1, 1'b0);
    vecs[13] = mk(1'b0,1'b1,1'b0,11'h000, 16'hA010, 11'h001, 11'h002, 1'b1, 1'b0);
    vecs[14] = mk(1'b0,1'b0,1'b0,11'h000, 16'h1003, 11'h002, 11'h003, 1'b1, 1'b0);
    vecs[15] = mk(1'b0,1'b1,1'b0,11'h000, 16'h1003, 11'h002, 11'h003, 1'b1, 1'b0);

    for (int i = 0; i < 16; i++) begin
      step(vecs[i].rst, vecs[i].stall, vecs[i].br, vecs[i].baddr);
      check_all("vec", i, vecs[i].instr, vecs[i].pc_o, vecs[i].addr, vecs[i].valid, vecs[i].halt);
    end

    // Fetch of the HLT word at address 3, then a branch that must be ignored when halted.
`ifdef BIP2_FETCH_HALT_DETECT_EN
    step(1'b0, 1'b0, 1'b0, 11'h000);
    check_all("hlt_fetch", 0, 16'h0011, 11'h003, 11'h003, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 11'h000);
    check_all("hlt_hold", 0, 16'h0011, 11'h003, 11'h003, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1, 11'h000);
    check_all("hlt_br", 0, 16'h0011, 11'h003, 11'h003, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 11'h000);
    check_all("hlt_stall", 0, 16'h0011, 11'h003, 11'h003, 1'b0, 1'b1);
`else
    step(1'b0, 1'b0, 1'b0, 11'h000);
    check_all("nohlt_fetch", 0, 16'h0011, 11'h003, 11'h004, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 11'h000);
    check_all("nohlt_next", 0, 16'hF804, 11'h004, 11'h005, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 11'h000);
    check_all("nohlt_br", 0, 16'hF804, 11'h004, 11'h000, 1'b0, 1'b0);
`endif

    // Reset from the halted (or running) state.
    step(1'b1, 1'b0, 1'b0, 11'h000);
    check_all("rst_halt", 0, 16'h0000, 11'h000, 11'h000, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 11'h000);
    check_all("resume", 0, 16'h0801, 11'h000, 11'h001, 1'b1, 1'b0);

    // Reset arriving on the same edge as a branch, right after another branch.
    step(1'b0, 1'b0, 1'b1, 11'h7FF);
    check_all("br_pre", 0, 16'h0801, 11'h000, 11'h7FF, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 11'h002);
    check_all("rst_br", 0, 16'h0000, 11'h000, 11'h000, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 11'h000);
    check_all("resume2", 0, 16'h0801, 11'h000, 11'h001, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 11'h000);
    check_all("resume2", 1, 16'hA010, 11'h001, 11'h002, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bip2_fetch.md
# bip2_fetch

Instruction fetch stage of the BIP-2 core. It drives the 11-bit address into the instruction ROM, which is combinational, and registers the returned 16-bit word into an instruction register. It maintains the program counter and applies branch redirects and stalls from the control unit. It also detects the HLT instruction and freezes fetch. The decode/control unit sits downstream and consumes the split opcode/operand.

## Interface
Parameters:
- `ADDR_W`, default 11: PC and ROM address width.
- `DATA_W`, default 16: instruction width.
- `OPC_W`, default 5: opcode field width. The opcode is bits [15:11] and the operand is bits [10:0].

Ports:
- `CLK_i`, in, 1: clock. Everything is on the rising edge.
- `RST_i`, in, 1: reset. Synchronous and active-high.
- `ADDR_im_o`, out, 11: ROM address. Driven directly from the PC register.
- `DATA_im_i`, in, 16: ROM data. Combinational from `ADDR_im_o`.
- `STALL_i`, in, 1: hold PC, IR and state.
- `BRANCH_EN_i`, in, 1: redirect fetch to `BRANCH_ADDR_i`.
- `BRANCH_ADDR_i`, in, 11: branch target.
- `INSTR_o`, out, 16: instruction register.
- `OPCODE_o`, out, 5: `INSTR_o[15:11]`.
- `OPERAND_o`, out, 11: `INSTR_o[10:0]`.
- `PC_o`, out, 11: address that `INSTR_o` was fetched from.
- `INSTR_VALID_o`, out, 1: `INSTR_o` holds a live instruction.
- `HALT_o`, out, 1: core is halted.

## Operation
- States are RUN and HALTED.
- Reset, which overrides everything including mid-branch or mid-stall:
  - PC = 0, `INSTR_o` = 0x0000, `PC_o` = 0, `INSTR_VALID_o` = 0, `HALT_o` = 0, state RUN.
  - All outputs take these values at the first edge with `RST_i` = 1.
- RUN, at each edge, in priority order:
  1. `BRANCH_EN_i` = 1: PC <= `BRANCH_ADDR_i`; `INSTR_VALID_o` <= 0, so the word at the old PC is squashed; IR is unchanged. Branch has priority over `STALL_i`.
  2. `STALL_i` = 1: PC, IR, `PC_o`, `INSTR_VALID_o` and state all hold.
  3. Fetched word has opcode 00000 (HLT): IR <= `DATA_im_i`; `PC_o` <= PC; `INSTR_VALID_o` <= 1; PC holds; state <= HALTED.
  4. Otherwise: IR <= `DATA_im_i`; `PC_o` <= PC; `INSTR_VALID_o` <= 1; PC <= PC + 1.
- PC increment is modulo 2^11, so 0x7FF wraps to 0x000 with no flag.
- HALTED:
  - `HALT_o` = 1 (registered, asserted on the edge entering HALTED).
  - `INSTR_VALID_o` <= 0 at the next edge after entry.
  - PC and `ADDR_im_o` frozen at the HLT address; IR holds the HLT word.
  - `BRANCH_EN_i` and `STALL_i` are ignored. Only `RST_i` exits.
- HLT detection uses the ROM word at fetch time, not the IR contents.

## Timing
- ROM read is zero-latency combinational. Fetch-to-IR latency is 1 cycle.
- First valid instruction: the first edge with `RST_i` = 0 loads ROM[0], so `INSTR_VALID_o` = 1 one cycle after reset release.
- Throughput is 1 instruction per cycle when there is no stall or branch.
- Branch penalty is 1 bubble. The edge with `BRANCH_EN_i` gives valid = 0; the next edge loads ROM[target] with valid = 1.
- A branch to the current PC, or a branch asserted while a stall is held, still squashes and reloads.
- `OPCODE_o`, `OPERAND_o` and `HALT_o` are functions of registered state only. There is no combinational path from any input to any output.

## Configuration
- Macro `BIP2_FETCH_HALT_DETECT_EN`.
- Defined: HLT detection and the HALTED state behave as above.
- Undefined:
  - Opcode 00000 is fetched like any other instruction and PC keeps incrementing.
  - `HALT_o` is tied to 0 and the HALTED state is not built.
  - Downstream control is then responsible for stopping the core.

## Test plan
Bench ROM model contents: ROM[0] = 0x0801, ROM[1] = 0xA010, ROM[2] = 0x1003, ROM[3] = 0x0011, ROM[0x7FF] = 0x0802.

1. Reset then release.
   - Reset: `INSTR_VALID_o` = 0, `ADDR_im_o` = 0.
   - Edge 1: `INSTR_o` = 0x0801, `OPCODE_o` = 0x01, `OPERAND_o` = 0x001, `PC_o` = 0.
   - Edge 2: `INSTR_o` = 0xA010, `OPCODE_o` = 0x14, `OPERAND_o` = 0x010, `PC_o` = 1.
2. Stall.
   - Hold `STALL_i` = 1 for 3 cycles after edge 2.
   - `INSTR_o` stays 0xA010 and `ADDR_im_o` stays 2.
   - On release, `INSTR_o` = 0x1003 at `PC_o` = 2.
3. Branch with simultaneous stall.
   - `BRANCH_EN_i` = 1, `STALL_i` = 1, `BRANCH_ADDR_i` = 0x7FF.
   - Next cycle: valid = 0, `ADDR_im_o` = 0x7FF.
   - Then `INSTR_o` = 0x0802 at `PC_o` = 0x7FF, and `ADDR_im_o` wraps to 0x000.
4. HLT with the macro defined.
   - Run to address 3 (0x0011): `INSTR_VALID_o` = 1 for one cycle with `OPCODE_o` = 0 and `HALT_o` = 1.
   - Then valid = 0 and `ADDR_im_o` stays 3.
   - A branch to 0 is ignored.
5. HLT with the macro undefined.
   - 0x0011 is fetched, `HALT_o` stays 0, and `ADDR_im_o` advances to 4.
6. Reset mid-branch and while HALTED.
   - Assert `RST_i` in either case.
   - Next edge: PC = 0, `HALT_o` = 0, valid = 0.
   - Normal fetch resumes from ROM[0].
